led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Sequencer and controller for the 8-LED front-panel bank. It derives a 1 ms tick from `i_clk` and steps a one-hot or fill pattern across the LEDs with a fixed dwell per step. It runs a programmable number of sweeps and reports completion. It sits between the button/command logic and the active-low LED pins, and exports its tick for other timer users.

## Interface
Parameters:
- `CLK_DIV`, 50000, `i_clk` cycles per tick (1 ms at 50 MHz); must be ≥ 2.
- `STEP_MS`, 30, ticks per step; range 1..255.

Ports:
- `i_clk`, in, 1, clock.
- `i_rstn`, in, 1, reset; asynchronous, active-low.
- `i_start`, in, 1, single-cycle pulse; start, or resume from pause.
- `i_pause`, in, 1, single-cycle pulse; freeze the sequence.
- `i_stop`, in, 1, single-cycle pulse; abort and blank the LEDs.
- `i_mode`, in, 2, pattern: 0 = shift-left, 1 = shift-right, 2 = bounce, 3 = fill.
- `i_repeat`, in, 4, sweeps to run; 0 = continuous.
- `o_busy`, out, 1, high in RUN or PAUSE.
- `o_done`, out, 1, single-cycle pulse when the programmed sweeps complete.
- `o_tick_1k`, out, 1, single-cycle pulse once per `CLK_DIV` cycles.
- `o_step`, out, 4, current step index.
- `o_led_on`, out, 8, LED drive, active-low.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE; `o_led_on` = 8'hFF; all other outputs 0; all counters 0.
- Prescaler:
  - Counts 0..`CLK_DIV`-1 and wraps.
  - `o_tick_1k` is high in the cycle the count equals `CLK_DIV`-1.
  - Free-running, except it clears to 0 when a start from IDLE is accepted.
- Dwell counter (8 bit): counts ticks in RUN only. At `STEP_MS`-1 together with a tick, it clears and the step advances.
- Step range per sweep:
  - Modes 0, 1, 3: steps 0..7.
  - Mode 2: steps 0..13.
- LED index for each step:
  - Mode 0: index = step.
  - Mode 1: index = 7-step.
  - Mode 2: index = step for step < 8, otherwise 14-step.
- LED pattern:
  - Modes 0–2: one-hot at the LED index.
  - Mode 3: bits 0..step all set.
  - `o_led_on` = ~pattern.
- End of sweep (last step's dwell expires):
  - The sweep counter (4 bit) increments and the step returns to 0.
  - If `i_repeat` ≠ 0 and the sweep count equals `i_repeat`, go to DONE.
- Transitions:
  - IDLE + start → RUN. `i_mode` and `i_repeat` are latched; step, dwell and sweep count clear.
  - RUN + pause → PAUSE. Dwell, step and LEDs hold.
  - PAUSE + start → RUN. Dwell resumes from its held value; the prescaler is not cleared.
  - RUN or PAUSE + stop → IDLE. LEDs go to FF; no `o_done`.
  - DONE → IDLE unconditionally after 1 cycle. `o_done` = 1 during DONE; LEDs go to FF on entry to DONE.
- Priority when pulses coincide: stop > pause > start.
  - Start in RUN or DONE is ignored.
  - Pause outside RUN is ignored.
  - Stop in IDLE is ignored.
- Latched mode/repeat are unaffected by input changes mid-run.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

## Timing
- Start accepted at edge N: at N+1, `o_busy` = 1, `o_step` = 0, and the step-0 pattern is on `o_led_on`.
- Every step lasts exactly `STEP_MS`×`CLK_DIV` cycles when there is no pause. This holds because the prescaler clears on start.
- Step update appears on the edge after the terminal tick cycle.
- `o_done` is asserted 1 cycle after the final step ends; `o_busy` drops in the same cycle.
- Pause/stop take effect at the next edge. A tick coincident with pause is not counted.
- Sweep counter saturates behaviour only matters for continuous mode: it wraps at 16 with no effect.

## Configuration
- `LED_SEQ_GAP_EN` defined: after each sweep, an extra gap step with all LEDs off (`o_led_on` = FF, `o_step` = 15) lasts `STEP_MS` ticks.
  - The gap counts as part of the sweep, so DONE follows the gap of the final sweep.
  - Pause and stop apply during the gap.
- Not defined: sweeps run back-to-back and there is no gap step.

## Test plan
Bench parameters: `CLK_DIV`=4, `STEP_MS`=2, so 1 step = 8 cycles.

- Mode 0, repeat 1, start → `o_led_on` goes FE, FD, FB … 7F, 8 cycles each. `o_done` pulses 1 cycle at cycle 65 after start; LEDs return to FF; `o_busy` = 0.
- Mode 2, repeat 2 → 14-step bounce (index 0..7..1) run twice. `o_done` pulses exactly once, 224 cycles after start plus 1.
- Mode 3, repeat 0 → fill pattern FE, FC … 00 repeating. Verify `o_busy` stays high after 3 sweeps and `o_done` never pulses; then stop → FF next cycle with no `o_done`.
- Mode 0: pause at cycle 11 (step 1), hold 20 cycles, then start → LEDs hold FD during the pause. Step 1 ends 5 dwell-cycles after resume, bounded by the tick phase. Start pulses during RUN are ignored.
- Pause and stop asserted in the same cycle → IDLE. Assert `i_rstn` low mid-step → all outputs return to reset values without waiting for a clock.
- With `LED_SEQ_GAP_EN`, mode 1, repeat 1 → 7F … FE, then FF with `o_step` = 15 for 8 cycles. `o_done` follows at cycle 73.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl -- front-panel LED bank sequencer.
//
// Derives a 1 ms tick from i_clk, then steps a one-hot or fill pattern across
// eight active-low LEDs with a fixed dwell of STEP_MS ticks per step. Runs
// i_repeat sweeps (0 = continuous) and pulses o_done when finished.
//
// Optional build macro: LED_SEQ_GAP_EN -- appends one all-off gap step
// (o_step = 15) to the end of every sweep.
//
// Ports:
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_start            pulse: start from IDLE, or resume from PAUSE
//   i_pause            pulse: freeze the sequence (RUN only)
//   i_stop             pulse: abort to IDLE, LEDs blank (RUN/PAUSE only)
//   i_mode[1:0]        0 shift-left, 1 shift-right, 2 bounce, 3 fill
//   i_repeat[3:0]      sweeps to run, 0 = continuous
//   o_busy             high in RUN or PAUSE
//   o_done             one-cycle pulse when the programmed sweeps complete
//   o_tick_1k          one-cycle pulse every CLK_DIV cycles
//   o_step[3:0]        current step index
//   o_led_on[7:0]      LED drive, active-low
module led_seq_ctrl #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned STEP_MS = 30
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic [1:0] i_mode,
  input  logic [3:0] i_repeat,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tick_1k,
  output logic [3:0] o_step,
  output logic [7:0] o_led_on
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0]  GAP_STEP = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    sweep_q, sweep_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    rep_q, rep_d;

  logic          tick;
  logic          start_acc;
  logic          dwell_end;
  logic [3:0]    last_step;
  logic [3:0]    sweep_inc;

  assign tick      = (pre_q == PW'(CLK_DIV - 1));
  assign start_acc = (state_q == S_IDLE) && i_start;
  assign dwell_end = tick && (dwell_q == 8'(STEP_MS - 1));
  assign last_step = (mode_q == 2'd2) ? 4'd13 : 4'd7;
  assign sweep_inc = sweep_q + 4'd1;

  // Prescaler clears on a fresh start so the first step gets a full dwell.
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    if (start_acc) pre_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      dwell_q <= '0;
      step_q  <= '0;
      sweep_q <= '0;
      mode_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      sweep_q <= sweep_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    step_d  = step_q;
    sweep_d = sweep_q;
    mode_d  = mode_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          mode_d  = i_mode;
          rep_d   = i_repeat;
          dwell_d = '0;
          step_d  = '0;
          sweep_d = '0;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d = S_IDLE;
          dwell_d = '0;
          step_d  = '0;
        end else if (i_pause) begin
          // a tick in this cycle is deliberately dropped
          state_d = S_PAUSE;
        end else if (dwell_end) begin
          dwell_d = '0;
`ifdef LED_SEQ_GAP_EN
          if (step_q == GAP_STEP) begin
            step_d  = '0;
            sweep_d = sweep_inc;
            if (rep_q != 4'd0 && sweep_inc == rep_q) state_d = S_DONE;
          end else if (step_q == last_step) begin
            step_d = GAP_STEP;
          end else begin
            step_d = step_q + 4'd1;
          end
`else
          if (step_q == last_step) begin
            step_d  = '0;
            sweep_d = sweep_inc;
            if (rep_q != 4'd0 && sweep_inc == rep_q) state_d = S_DONE;
          end else begin
            step_d = step_q + 4'd1;
          end
`endif
        end else if (tick) begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          state_d = S_IDLE;
          dwell_d = '0;
          step_d  = '0;
        end else if (i_start) begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // LED pattern decode from the held step.
  logic [3:0] idx4;
  logic [7:0] pat;

  always_comb begin
    idx4 = step_q;
    case (mode_q)
      2'd1:    idx4 = 4'd7 - step_q;
      2'd2:    idx4 = (step_q < 4'd8) ? step_q : 4'd14 - step_q;
      default: idx4 = step_q;
    endcase
    pat = '0;
    if (mode_q == 2'd3) begin
      for (int i = 0; i < 8; i++) pat[i] = (4'(i) <= step_q);
    end else begin
      pat = 8'h01 << idx4[2:0];
    end
  end

  assign o_busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign o_done    = (state_q == S_DONE);
  assign o_tick_1k = tick;
  assign o_step    = step_q;
  // Gap step (only reachable with the gap build) shows all LEDs off.
  assign o_led_on  = (o_busy && step_q != GAP_STEP) ? ~pat : 8'hFF;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] rep = 4'd0;
  logic       o_busy, o_done, o_tick_1k;
  logic [3:0] o_step;
  logic [7:0] o_led_on;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.CLK_DIV(4), .STEP_MS(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_mode(mode), .i_repeat(rep), .o_busy(o_busy), .o_done(o_done),
    .o_tick_1k(o_tick_1k), .o_step(o_step), .o_led_on(o_led_on)
  );

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic do_start(input logic [1:0] m, input logic [3:0] r);
    @(posedge clk); #1;
    mode = m; rep = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #12;
    n_cmp++;
    if ({o_busy, o_done, o_tick_1k, o_step, o_led_on} !== {3'b000, 4'd0, 8'hFF}) begin
      n_err++;
      $display("FAIL reset act=%b_%h_%h exp=000_0_ff", {o_busy, o_done, o_tick_1k}, o_step, o_led_on);
    end
    @(negedge clk); rstn = 1'b1;
    // pause/stop in IDLE are ignored
    @(negedge clk); pause = 1'b1; stop = 1'b1;
    @(negedge clk); pause = 1'b0; stop = 1'b0;
    n_cmp++;
    if ({o_busy, o_done, o_led_on} !== {2'b00, 8'hFF}) begin
      n_err++;
      $display("FAIL idle_ignore act=%b_%h exp=00_ff", {o_busy, o_done}, o_led_on);
    end
  endtask

  task automatic test_mode0;
    logic [14:0] exp_v;
    do_start(2'd0, 4'd1);
    for (int k = 0; k <= 65; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < 64) exp_v = {1'b1, 1'b0, (k % 4 == 3), 4'(k / 8), ~(8'h01 << (k / 8))};
      else        exp_v = {1'b0, (k == 64), (k % 4 == 3), 4'd0, 8'hFF};
      n_cmp++;
      if ({o_busy, o_done, o_tick_1k, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL mode0 k=%0d act=%h exp=%h", k, {o_busy, o_done, o_tick_1k, o_step, o_led_on}, exp_v);
      end
      // latched mode/repeat must ignore these
      if (k == 3) begin mode = 2'd2; rep = 4'd3; end
    end
  endtask

  task automatic test_bounce;
    logic [13:0] exp_v;
    int s, idx, dones;
    dones = 0;
    do_start(2'd2, 4'd2);
    for (int k = 0; k <= 225; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      s   = (k / 8) % 14;
      idx = (s < 8) ? s : 14 - s;
      if (k < 224) exp_v = {2'b10, 4'(s), ~(8'h01 << idx)};
      else         exp_v = {1'b0, (k == 224), 4'd0, 8'hFF};
      if (o_done) dones++;
      n_cmp++;
      if ({o_busy, o_done, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL bounce k=%0d act=%h exp=%h", k, {o_busy, o_done, o_step, o_led_on}, exp_v);
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL bounce_done_count act=%0d exp=1", dones);
    end
  endtask

  task automatic test_fill_continuous;
    logic [13:0] exp_v;
    int s;
    do_start(2'd3, 4'd0);
    for (int k = 0; k <= 201; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      s = (k / 8) % 8;
      if (k < 200) exp_v = {2'b10, 4'(s), ~8'((16'h2 << s) - 16'h1)};
      else         exp_v = {2'b00, 4'd0, 8'hFF};
      n_cmp++;
      if ({o_busy, o_done, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL fill k=%0d act=%h exp=%h", k, {o_busy, o_done, o_step, o_led_on}, exp_v);
      end
      stop = (k == 199);
    end
    stop = 1'b0;
  endtask

  task automatic test_pause_resume;
    logic [13:0] exp_v;
    int s;
    do_start(2'd0, 4'd1);
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      s = (k < 8) ? 0 : (k < 36) ? 1 : (k < 44) ? 2 : 3;
      if (k < 50) exp_v = {2'b10, 4'(s), ~(8'h01 << s)};
      else        exp_v = {2'b00, 4'd0, 8'hFF};
      n_cmp++;
      if ({o_busy, o_done, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL pause k=%0d act=%h exp=%h", k, {o_busy, o_done, o_step, o_led_on}, exp_v);
      end
      pause = (k == 10);
      start = (k == 30) || (k == 39);
      stop  = (k == 49);
    end
    pause = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_pause_stop;
    logic [13:0] exp_v;
    do_start(2'd0, 4'd1);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_v = (k < 6) ? {2'b10, 4'd0, 8'hFE} : {2'b00, 4'd0, 8'hFF};
      n_cmp++;
      if ({o_busy, o_done, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL pause_stop k=%0d act=%h exp=%h", k, {o_busy, o_done, o_step, o_led_on}, exp_v);
      end
      pause = (k == 5);
      stop  = (k == 5);
    end
    pause = 1'b0; stop = 1'b0;
  endtask

  task automatic test_mode1_end;
    logic [13:0] exp_v;
    int last;
`ifdef LED_SEQ_GAP_EN
    last = 72;
`else
    last = 64;
`endif
    do_start(2'd1, 4'd1);
    for (int k = 0; k <= last + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < 64)        exp_v = {2'b10, 4'(k / 8), ~(8'h80 >> (k / 8))};
      else if (k < last) exp_v = {2'b10, 4'd15, 8'hFF};
      else               exp_v = {1'b0, (k == last), 4'd0, 8'hFF};
      n_cmp++;
      if ({o_busy, o_done, o_step, o_led_on} !== exp_v) begin
        n_err++;
        $display("FAIL mode1_end k=%0d act=%h exp=%h", k, {o_busy, o_done, o_step, o_led_on}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset;
    do_start(2'd3, 4'd0);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_busy, o_step, o_led_on} !== {1'b1, 4'd1, 8'hFC}) begin
      n_err++;
      $display("FAIL pre_reset act=%h exp=%h", {o_busy, o_step, o_led_on}, {1'b1, 4'd1, 8'hFC});
    end
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({o_busy, o_done, o_tick_1k, o_step, o_led_on} !== {3'b000, 4'd0, 8'hFF}) begin
      n_err++;
      $display("FAIL async_reset act=%b_%h_%h exp=000_0_ff", {o_busy, o_done, o_tick_1k}, o_step, o_led_on);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_bounce();
    test_fill_continuous();
    test_pause_resume();
    test_pause_stop();
    test_mode1_end();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
